la_scanctrl: RTL and testbench

Scan-chain driver: the initiating end of the scan interface that scan flops (d, si, se, clk -> q) present. It accepts an N-bit test pattern and shifts it into an external chain by driving se/si. It then pulses one or more functional capture cycles and shifts the captured response out through so. It returns the response as a parallel word. It sits in test/BIST logic beside the chain and shares the chain's clk.

---
 rtl/la_scanctrl_pkg.sv | 28 ++
 rtl/la_scanctrl_shreg.sv | 39 +++
 rtl/la_scanctrl.sv | 155 +++++++++++++++
 tb/tb_la_scanctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/la_scanctrl_pkg.sv
// la_scanctrl_pkg: shared definitions for the scan-chain driver.
//   scan_state_t : sequencer phases. The encoding is fixed because test
//                  logic elsewhere decodes the phase directly.
//   phase_se()   : the scan-enable level the chain needs during a phase.
package la_scanctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CAPT   = 2'd2,
    UNLOAD = 2'd3
  } scan_state_t;

  // Shift phases run the chain in scan mode. Capture and idle run it in
  // functional mode.
  function automatic logic phase_se(input scan_state_t st);
    logic se_v;
    case (st)
      LOAD:    se_v = 1'b1;
      UNLOAD:  se_v = 1'b1;
      CAPT:    se_v = 1'b0;
      IDLE:    se_v = 1'b0;
      default: se_v = 1'b0;
    endcase
    return se_v;
  endfunction

endpackage

// File: rtl/la_scanctrl_shreg.sv
// la_scanctrl_shreg: W-bit shift register with parallel load. It shifts
// toward the MSB and takes new data in at bit 0.
//   clk   in   clock
//   rst   in   synchronous reset, active-high, clears the register
//   load  in   parallel load from din (has priority over shift)
//   shift in   shift one place: q <= {q[W-2:0], sin}
//   din   in   W  parallel load data
//   sin   in   serial input
//   q     out  W  register contents; q[W-1] is the serial output
module la_scanctrl_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  input  logic         sin,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Shift register storage: reset, parallel load, or shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= din;
    end else if (shift) begin
      q_r <= {q_r[W-2:0], sin};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/la_scanctrl.sv
// la_scanctrl: scan-chain driver. It loads an N-bit pattern into an external
// scan chain, runs CAPCYCLES functional capture cycles, and unloads the
// response as a parallel word.
//   clk     in   clock, shared with the scan chain
//   rst     in   synchronous reset, active-high
//   start   in   request one load/capture/unload sequence
//   pattern in   N  pattern to load, sampled on an accepted start
//   ready   out  idle and able to accept start
//   se      out  scan enable to the chain (registered)
//   si      out  scan data into chain head, flop 0 (registered)
//   so      in   scan data from chain tail, flop N-1
//   done    out  one-cycle pulse, result valid
//   result  out  N  captured response, result[i] = flop i after capture
module la_scanctrl
  import la_scanctrl_pkg::*;
#(
  parameter int N         = 8,
  parameter int CAPCYCLES = 1,
  parameter int CW        = $clog2(N + 1),
  parameter     PROP      = "DEFAULT"
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] pattern,
  output logic         ready,
  output logic         se,
  output logic         si,
  input  logic         so,
  output logic         done,
  output logic [N-1:0] result
);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CAPT_LAST = CW'(CAPCYCLES - 1);
  localparam logic [CW-1:0] UNLD_LAST = CW'(N - 1);
  localparam int unused_prop_bits = $bits(PROP);

  scan_state_t  state_r;
  logic [CW-1:0] cnt_r;
  logic          se_r;
  logic          ready_r;
  logic          done_r;
  logic [N-1:0]  result_r;

  logic          accept_s;
  logic          load_shift_s;
  logic          unload_shift_s;
  logic [N-1:0]  load_q_s;
  logic [N-1:0]  unload_q_s;
  logic          unused_s;

  assign accept_s       = (state_r == IDLE) && start;
  assign load_shift_s   = (state_r == LOAD);
  assign unload_shift_s = (state_r == UNLOAD);

  // Load path. The MSB register drives si directly, so the first pattern bit
  // is already on si in the cycle after acceptance. Zeros shift in behind
  // the pattern, so si returns to 0 once the pattern is out and stays there.
  la_scanctrl_shreg #(.W(N)) u_load (
    .clk   (clk),
    .rst   (rst),
    .load  (accept_s),
    .shift (load_shift_s),
    .din   (pattern),
    .sin   (1'b0),
    .q     (load_q_s)
  );

  // Unload path. The shift happens on the same edge that clocks the chain,
  // so it captures so as the chain tail presented it before the shift.
  la_scanctrl_shreg #(.W(N)) u_unload (
    .clk   (clk),
    .rst   (rst),
    .load  (accept_s),
    .shift (unload_shift_s),
    .din   ({N{1'b0}}),
    .sin   (so),
    .q     (unload_q_s)
  );

  // Only the MSB of the load path and the low N-1 bits of the unload path
  // carry meaning. The remaining bits are intentionally left unused.
  assign unused_s = ^{load_q_s[N-2:0], unload_q_s[N-1]};

  // Sequencer: phase, phase cycle counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      se_r     <= 1'b0;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= LOAD;
            cnt_r   <= '0;
            se_r    <= phase_se(LOAD);
            ready_r <= 1'b0;
          end
        end
        LOAD: begin
          if (cnt_r == LOAD_LAST) begin
            state_r <= CAPT;
            cnt_r   <= '0;
            se_r    <= phase_se(CAPT);
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        CAPT: begin
          if (cnt_r == CAPT_LAST) begin
            state_r <= UNLOAD;
            cnt_r   <= '0;
            se_r    <= phase_se(UNLOAD);
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        UNLOAD: begin
          if (cnt_r == UNLD_LAST) begin
            // The Nth sample is still on so at this edge, so it is merged in
            // directly instead of waiting one cycle for the shift register.
            state_r  <= IDLE;
            cnt_r    <= '0;
            se_r     <= phase_se(IDLE);
            ready_r  <= 1'b1;
            done_r   <= 1'b1;
            result_r <= {unload_q_s[N-2:0], so};
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          se_r    <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign ready  = ready_r;
  assign se     = se_r;
  assign si     = load_q_s[N-1];
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_la_scanctrl.sv
// tb_la_scanctrl: drives two la_scanctrl instances (N=4, CAPCYCLES=1 and 2).
// Each instance has its own behavioural 4-flop scan chain whose functional
// input is d_i = ~q_i. The stimulus side predicts the per-cycle se/si/ready
// trace and pushes the expected done/result into a scoreboard. A negedge
// monitor compares the DUT outputs against those predictions.
module tb_la_scanctrl;

  localparam int N  = 4;
  localparam int C0 = 1;
  localparam int C1 = 2;
  localparam int K  = 1 << 20;

  typedef struct packed {
    int           due;
    logic [N-1:0] res;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         start1 = 1'b0;
  logic         start2 = 1'b0;
  logic [N-1:0] pattern = '0;

  logic         ready1, se1, si1, so1, done1;
  logic         ready2, se2, si2, so2, done2;
  logic [N-1:0] result1, result2;
  logic [N-1:0] ch1 = '0;
  logic [N-1:0] ch2 = '0;

  la_scanctrl #(.N(N), .CAPCYCLES(C0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pattern(pattern), .ready(ready1),
    .se(se1), .si(si1), .so(so1), .done(done1), .result(result1)
  );

  la_scanctrl #(.N(N), .CAPCYCLES(C1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .pattern(pattern), .ready(ready2),
    .se(se2), .si(si2), .so(so2), .done(done2), .result(result2)
  );

  // Scan chains: si -> flop0 -> ... -> flop N-1 -> so; functional d = ~q.
  assign so1 = ch1[N-1];
  assign so2 = ch2[N-1];
  always @(posedge clk) begin
    if (se1 === 1'b1) ch1 <= {ch1[N-2:0], si1};
    else              ch1 <= ~ch1;
    if (se2 === 1'b1) ch2 <= {ch2[N-2:0], si2};
    else              ch2 <= ~ch2;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  nvec = 0;
  int  nerr = 0;
  bit  chk_en = 1'b0;
  int  free_at [2];
  sb_t sb0 [$];
  sb_t sb1 [$];
  logic [2:0] exp_tr [int];   // {se, si, ready} keyed by d*K + cycle

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, d + 1, cyc, act, exp);
    end
  endtask

  function automatic int sb_size(input int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic sb_t sb_pop(input int d);
    if (d == 0) return sb0.pop_front();
    else        return sb1.pop_front();
  endfunction

  function automatic int sb_front_due(input int d);
    if (d == 0) return sb0[0].due;
    else        return sb1[0].due;
  endfunction

  // Reference model for one clock edge e. A started sequence loads
  // pattern[N-1] first, idles se for C capture cycles, then unloads N bits.
  // Each capture inverts every flop, so the response is the pattern
  // inverted C times.
  task automatic model_edge(input int d, input int e, input bit r, input bit s,
                            input logic [N-1:0] p);
    int           c;
    int           t;
    logic [N-1:0] res;
    sb_t          it;
    c = (d == 0) ? C0 : C1;
    t = 2 * N + c;
    if (r) begin
      for (int k = e + 1; k <= e + 2 * N + C1 + 2; k++)
        if (exp_tr.exists(d * K + k)) exp_tr.delete(d * K + k);
      if (d == 0) sb0.delete();
      else        sb1.delete();
      free_at[d] = e + 1;
    end else if (s && e >= free_at[d]) begin
      for (int j = 0; j < t; j++) begin
        if (j < N)          exp_tr[d * K + e + 1 + j] = {1'b1, p[N-1-j], 1'b0};
        else if (j < N + c) exp_tr[d * K + e + 1 + j] = 3'b000;
        else                exp_tr[d * K + e + 1 + j] = 3'b100;
      end
      res = p;
      for (int k = 0; k < c; k++) res = ~res;
      it.due = e + t + 1;
      it.res = res;
      if (d == 0) sb0.push_back(it);
      else        sb1.push_back(it);
      free_at[d] = e + t + 1;
    end
  endtask

  // Monitor for one DUT: trace check every cycle, scoreboard pop on done.
  task automatic mon(input int d, input logic se, input logic si, input logic rdy,
                     input logic dn, input logic [N-1:0] res);
    int         key;
    logic [2:0] v;
    sb_t        it;
    if (chk_en) begin
      key = d * K + cyc;
      v = 3'b001;
      if (exp_tr.exists(key)) begin
        v = exp_tr[key];
        exp_tr.delete(key);
      end
      chk("se", d, 32'(se), 32'(v[2]));
      chk("si", d, 32'(si), 32'(v[1]));
      chk("ready", d, 32'(rdy), 32'(v[0]));
      if (dn !== 1'b0) begin
        if (sb_size(d) == 0) begin
          chk("done_unexpected", d, 32'(dn), 32'd0);
        end else begin
          it = sb_pop(d);
          chk("done_cycle", d, 32'(cyc), 32'(it.due));
          chk("result", d, 32'(res), 32'(it.res));
        end
      end else if (sb_size(d) != 0 && sb_front_due(d) <= cyc) begin
        it = sb_pop(d);
        chk("done_missing", d, 32'(dn), 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, se1, si1, ready1, done1, result1);
    mon(1, se2, si2, ready2, done2, result2);
  end

  // One clock of stimulus: drive at negedge, update the model at the edge.
  task automatic step(input bit r, input bit s1, input bit s2, input logic [N-1:0] p);
    int e;
    @(negedge clk);
    rst = r;
    start1 = s1;
    start2 = s2;
    pattern = p;
    e = cyc;
    @(posedge clk);
    model_edge(0, e, r, s1, p);
    model_edge(1, e, r, s2, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    free_at[0] = 0;
    free_at[1] = 0;
    // 1. Reset for two cycles with start held high.
    step(1'b1, 1'b1, 1'b1, 4'b1010);
    step(1'b1, 1'b1, 1'b1, 4'b1010);
    chk_en = 1'b1;
    #1;
    chk("rst_result", 0, 32'(result1), 32'd0);
    chk("rst_result", 1, 32'(result2), 32'd0);
    chk("rst_done", 0, 32'(done1), 32'd0);
    idle(2);
    // 2 and 3. Basic 1010, then 0011 started in the done cycle.
    step(1'b0, 1'b1, 1'b0, 4'b1010);
    idle(9);
    step(1'b0, 1'b1, 1'b0, 4'b0011);
    idle(11);
    // 4. Start during LOAD is ignored.
    step(1'b0, 1'b1, 1'b0, 4'b1000);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 4'b1111);
    idle(11);
    // 5. Reset in the second UNLOAD cycle, then a clean 0001 run.
    step(1'b0, 1'b1, 1'b0, 4'b1010);
    idle(6);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    #1;
    chk("midrst_result", 0, 32'(result1), 32'd0);
    chk("midrst_ready", 0, 32'(ready1), 32'd1);
    step(1'b0, 1'b1, 1'b0, 4'b0001);
    idle(11);
    // 6. Two capture cycles.
    step(1'b0, 1'b0, 1'b1, 4'b1010);
    idle(12);
    // Random traffic on both instances with rare resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), 4'($urandom));
    end
    idle(14);
    chk("sb_drained", 0, 32'(sb_size(0)), 32'd0);
    chk("sb_drained", 1, 32'(sb_size(1)), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
